// File: rtl/rambus_pkg.sv
// rambus_pkg: widths and types for the shared-RAM bus (rambus).
//   RAMBUS_ADDR_W / RAMBUS_DATA_W / RAMBUS_SEL_W : bus field widths
//   rambus_rsp_state_t                          : responder FSM states
//   addr_in_range()                             : word address vs. implemented depth
package rambus_pkg;

  localparam int RAMBUS_ADDR_W = 8;
  localparam int RAMBUS_DATA_W = 32;
  localparam int RAMBUS_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } rambus_rsp_state_t;

  function automatic logic addr_in_range(input logic [RAMBUS_ADDR_W-1:0] adr,
                                         input int unsigned depth);
    return 32'(adr) < depth;
  endfunction

endpackage

// File: rtl/rambus_sram_responder.sv
// rambus_sram_responder: Wishbone classic responder that turns each single-word
// rambus transfer into exactly one cycle on a single-port OpenRAM-style SRAM.
//
// Parameters:
//   DEPTH  : implemented 32-bit words; addresses >= DEPTH are out of range
//            (acked, never touch the SRAM, read back as zero)
//   RD_LAT : SRAM read latency in edges from capture edge to valid ram_dout_i (1..3)
//
// Ports:
//   wb_clk_i, wb_rst_ni      : clock, asynchronous active-low reset
//   rambus_wb_cyc_i/stb_i    : bus cycle / strobe
//   rambus_wb_we_i           : 1 = write
//   rambus_wb_sel_i[3:0]     : byte enables
//   rambus_wb_adr_i[7:0]     : word address
//   rambus_wb_dat_i[31:0]    : write data
//   rambus_wb_ack_o          : single-cycle acknowledge
//   rambus_wb_dat_o[31:0]    : read data, held until the next read completes
//   ram_csb_o / ram_web_o    : SRAM chip select / write enable, active-low
//   ram_wmask_o[3:0]         : SRAM byte write mask
//   ram_addr_o / ram_din_o   : SRAM address / write data
//   ram_dout_i               : SRAM read data
//
// Bus handshake: a request is (cyc & stb) sampled only in IDLE. The responder
// answers with one ack pulse per sampled request; the initiator must drop or
// change its request by the end of the ack cycle. If cyc falls while the
// SRAM access is in flight, the access still completes but no ack is given.
//
// The FSM state is kept in the signal `state` (rambus_rsp_state_t) so it can
// be probed hierarchically.
module rambus_sram_responder
  import rambus_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     rambus_wb_cyc_i,
  input  logic                     rambus_wb_stb_i,
  input  logic                     rambus_wb_we_i,
  input  logic [RAMBUS_SEL_W-1:0]  rambus_wb_sel_i,
  input  logic [RAMBUS_ADDR_W-1:0] rambus_wb_adr_i,
  input  logic [RAMBUS_DATA_W-1:0] rambus_wb_dat_i,
  output logic                     rambus_wb_ack_o,
  output logic [RAMBUS_DATA_W-1:0] rambus_wb_dat_o,
  output logic                     ram_csb_o,
  output logic                     ram_web_o,
  output logic [RAMBUS_SEL_W-1:0]  ram_wmask_o,
  output logic [RAMBUS_ADDR_W-1:0] ram_addr_o,
  output logic [RAMBUS_DATA_W-1:0] ram_din_o,
  input  logic [RAMBUS_DATA_W-1:0] ram_dout_i
);

  rambus_rsp_state_t state, state_d;

  // Request registers. Address, data and byte mask are captured directly into
  // the registered SRAM outputs, so only direction and range need their own flops.
  logic req_we, req_we_d;
  logic req_oor, req_oor_d;
  // Set once cyc is seen low during the in-flight access; suppresses the ack.
  logic aborted, aborted_d;
  logic [1:0] lat_cnt, lat_cnt_d;

  logic                     ack_d;
  logic [RAMBUS_DATA_W-1:0] dat_d;
  logic                     csb_d;
  logic                     web_d;
  logic [RAMBUS_SEL_W-1:0]  wmask_d;
  logic [RAMBUS_ADDR_W-1:0] addr_d;
  logic [RAMBUS_DATA_W-1:0] din_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state           <= IDLE;
      req_we          <= 1'b0;
      req_oor         <= 1'b0;
      aborted         <= 1'b0;
      lat_cnt         <= '0;
      rambus_wb_ack_o <= 1'b0;
      rambus_wb_dat_o <= '0;
      ram_csb_o       <= 1'b1;
      ram_web_o       <= 1'b1;
      ram_wmask_o     <= '0;
      ram_addr_o      <= '0;
      ram_din_o       <= '0;
    end else begin
      state           <= state_d;
      req_we          <= req_we_d;
      req_oor         <= req_oor_d;
      aborted         <= aborted_d;
      lat_cnt         <= lat_cnt_d;
      rambus_wb_ack_o <= ack_d;
      rambus_wb_dat_o <= dat_d;
      ram_csb_o       <= csb_d;
      ram_web_o       <= web_d;
      ram_wmask_o     <= wmask_d;
      ram_addr_o      <= addr_d;
      ram_din_o       <= din_d;
    end
  end

  // Every output is the registered form of a *_d value computed here, so the
  // SRAM strobe is visible during the ACCESS cycle and ack during the ACK cycle.
  always_comb begin
    state_d   = state;
    req_we_d  = req_we;
    req_oor_d = req_oor;
    aborted_d = aborted;
    lat_cnt_d = lat_cnt;
    ack_d     = 1'b0;
    dat_d     = rambus_wb_dat_o;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    wmask_d   = '0;
    addr_d    = ram_addr_o;
    din_d     = ram_din_o;

    case (state)
      IDLE: begin
        if (rambus_wb_cyc_i && rambus_wb_stb_i) begin
          state_d   = ACCESS;
          req_we_d  = rambus_wb_we_i;
          req_oor_d = !addr_in_range(rambus_wb_adr_i, DEPTH);
          aborted_d = 1'b0;
          addr_d    = rambus_wb_adr_i;
          din_d     = rambus_wb_dat_i;
          if (!req_oor_d) begin
            csb_d   = 1'b0;
            web_d   = !rambus_wb_we_i;
            wmask_d = rambus_wb_we_i ? rambus_wb_sel_i : '0;
          end
        end
      end

      ACCESS: begin
        // This edge is the SRAM capture edge; the access is committed
        // regardless of what the bus does from here on.
        aborted_d = aborted || !rambus_wb_cyc_i;
        if (req_we) begin
          state_d = ACK;
          ack_d   = !aborted_d;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = 2'(RD_LAT - 1);
        end
      end

      WAIT: begin
        aborted_d = aborted || !rambus_wb_cyc_i;
        if (lat_cnt == 2'd0) begin
          state_d = ACK;
          ack_d   = !aborted_d;
          dat_d   = req_oor ? '0 : ram_dout_i;
        end else begin
          lat_cnt_d = lat_cnt - 2'd1;
        end
      end

      ACK: begin
        // Ack is already registered; returning to IDLE here guarantees the
        // same strobe is not sampled again during the ack cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rambus_sram_responder.sv
// tb_rambus_sram_responder: bench for rambus_sram_responder with a behavioural
// SRAM (configurable read latency) and a word-level reference memory.
module tb_rambus_sram_responder;

  localparam int DEPTH  = 128;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        csb, web;
  logic [3:0]  wmask;
  logic [7:0]  ram_addr;
  logic [31:0] din, dout;

  rambus_sram_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .rambus_wb_cyc_i (cyc),
    .rambus_wb_stb_i (stb),
    .rambus_wb_we_i  (we),
    .rambus_wb_sel_i (sel),
    .rambus_wb_adr_i (adr),
    .rambus_wb_dat_i (wdat),
    .rambus_wb_ack_o (ack),
    .rambus_wb_dat_o (rdat),
    .ram_csb_o       (csb),
    .ram_web_o       (web),
    .ram_wmask_o     (wmask),
    .ram_addr_o      (ram_addr),
    .ram_din_o       (din),
    .ram_dout_i      (dout)
  );

  // ---------------- behavioural SRAM ----------------
  // Read data appears after capture edge + (RD_LAT-1), so it is stable for
  // sampling exactly RD_LAT edges after capture; other cycles carry X.
  logic [31:0] sram [256];
  logic [31:0] rd_pipe [RD_LAT];
  int          acc_addr [256];
  int          acc_total = 0;
  int          ack_total = 0;

  always @(posedge clk) begin
    if (!csb) begin
      acc_addr[ram_addr] <= acc_addr[ram_addr] + 1;
      acc_total          <= acc_total + 1;
      if (!web)
        for (int b = 0; b < 4; b++)
          if (wmask[b]) sram[ram_addr][8*b +: 8] <= din[8*b +: 8];
    end
    rd_pipe[0] <= (!csb && web) ? sram[ram_addr] : 32'hxxxx_xxxx;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ack) ack_total <= ack_total + 1;
  end
  assign dout = rd_pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = 32'h0;
  int n_checks = 0;
  int n_pass   = 0;

  // One complete transfer. Called at a negedge with the DUT in IDLE.
  // Leaves cyc/stb high when keep is set (back-to-back issue).
  task automatic xfer(input logic w, input logic [7:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit keep, output logic [31:0] got_d);
    bit          in_rng;
    bit          got;
    int          lat;
    int          exp_lat;
    logic [31:0] exp_d;
    in_rng  = (int'(a) < DEPTH);
    exp_lat = w ? 1 : 1 + RD_LAT;
    if (w) begin
      if (in_rng)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_q.push_back(in_rng ? ref_mem[a] : 32'h0);
    end

    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    @(posedge clk);  // T0
    @(negedge clk);  // ACCESS cycle
    n_checks++;
    if (csb !== !in_rng) $display("FAIL access_csb adr=%h got %b exp %b", a, csb, !in_rng);
    else n_pass++;
    if (in_rng) begin
      n_checks++;
      if ({web, wmask, ram_addr} !== {!w, (w ? s : 4'h0), a})
        $display("FAIL access_ctrl adr=%h got web=%b wmask=%h addr=%h exp web=%b wmask=%h addr=%h",
                 a, web, wmask, ram_addr, !w, (w ? s : 4'h0), a);
      else n_pass++;
      if (w) begin
        n_checks++;
        if (din !== d) $display("FAIL access_din adr=%h got %h exp %h", a, din, d);
        else n_pass++;
      end
    end

    got = 0; lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack === 1'b1) begin got = 1; lat = i; end
    end
    n_checks++;
    if (lat != exp_lat) $display("FAIL ack_latency adr=%h we=%b got %0d exp %0d (0=none)", a, w, lat, exp_lat);
    else n_pass++;

    got_d = rdat;
    if (!w) begin
      exp_d = exp_q.pop_front();
      last_rd = exp_d;
      n_checks++;
      if (rdat !== exp_d) $display("FAIL read_data adr=%h got %h exp %h", a, rdat, exp_d);
      else n_pass++;
    end else begin
      n_checks++;
      if (rdat !== last_rd) $display("FAIL read_hold adr=%h got %h exp %h", a, rdat, last_rd);
      else n_pass++;
    end

    if (!keep) begin cyc = 1'b0; stb = 1'b0; end
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) $display("FAIL ack_pulse adr=%h got %b exp 0", a, ack);
    else n_pass++;
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if ({ack, rdat, csb, web, wmask, ram_addr, din} !==
        {1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 8'h0, 32'h0})
      $display("FAIL %s got ack=%b dat=%h csb=%b web=%b wmask=%h addr=%h din=%h exp 0/0/1/1/0/0/0",
               tag, ack, rdat, csb, web, wmask, ram_addr, din);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_release");
    last_rd = 32'h0;
  endtask

  task automatic test_basic();
    logic [31:0] r;
    xfer(1'b1, 8'h05, 4'hF, 32'hDEAD_BEEF, 0, r);
    xfer(1'b0, 8'h05, 4'hF, 32'h0, 0, r);
    n_checks++;
    if (r !== 32'hDEAD_BEEF) $display("FAIL basic_read got %h exp deadbeef", r);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    xfer(1'b1, 8'h10, 4'hF, 32'h1122_3344, 0, r);
    xfer(1'b1, 8'h10, 4'h5, 32'hAABB_CCDD, 0, r);
    xfer(1'b0, 8'h10, 4'hF, 32'h0, 0, r);
    n_checks++;
    if (r !== 32'h11BB_33DD) $display("FAIL byte_lanes got %h exp 11bb33dd", r);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] r;
    int acc0, ack0;
    acc0 = acc_total; ack0 = ack_total;
    xfer(1'b1, 8'h80, 4'hF, 32'h1234_5678, 0, r);
    xfer(1'b0, 8'h80, 4'hF, 32'h0, 0, r);
    n_checks++;
    if (acc_total != acc0) $display("FAIL oor_no_sram got %0d accesses exp 0", acc_total - acc0);
    else n_pass++;
    n_checks++;
    if (ack_total - ack0 != 2) $display("FAIL oor_acks got %0d exp 2", ack_total - ack0);
    else n_pass++;
    n_checks++;
    if (r !== 32'h0) $display("FAIL oor_read got %h exp 00000000", r);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int a1, a2, ack0;
    // Seed known contents first.
    xfer(1'b1, 8'h01, 4'hF, 32'h0101_A5A5, 0, r);
    xfer(1'b1, 8'h02, 4'hF, 32'h0202_5A5A, 0, r);
    a1 = acc_addr[1]; a2 = acc_addr[2]; ack0 = ack_total;
    xfer(1'b0, 8'h01, 4'hF, 32'h0, 1, r);
    xfer(1'b0, 8'h02, 4'hF, 32'h0, 0, r);
    repeat (6) @(negedge clk);
    n_checks++;
    if (acc_addr[1] - a1 != 1 || acc_addr[2] - a2 != 1)
      $display("FAIL b2b_accesses got %0d/%0d exp 1/1", acc_addr[1] - a1, acc_addr[2] - a2);
    else n_pass++;
    n_checks++;
    if (ack_total - ack0 != 2) $display("FAIL b2b_acks got %0d exp 2", ack_total - ack0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] r;
    int ack0;
    ack0 = ack_total;
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 8'h05; wdat = 0;
    @(posedge clk);  // T0
    @(negedge clk);  // ACCESS
    @(posedge clk);  // capture, enter WAIT
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_read");
    cyc = 0; stb = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack_total != ack0) $display("FAIL reset_no_ack got %0d acks exp 0", ack_total - ack0);
    else n_pass++;
    xfer(1'b1, 8'h06, 4'hF, 32'hCAFE_0006, 0, r);
    xfer(1'b0, 8'h06, 4'hF, 32'h0, 0, r);
  endtask

  task automatic test_abort_write();
    logic [31:0] r;
    logic [31:0] d;
    int ack0;
    d = $urandom;
    ack0 = ack_total;
    for (int b = 0; b < 4; b++) ref_mem[8'h20][8*b +: 8] = d[8*b +: 8];
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 8'h20; wdat = d;
    @(posedge clk);  // T0
    @(negedge clk);  // ACCESS
    cyc = 0; stb = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ack_total != ack0) $display("FAIL abort_no_ack got %0d acks exp 0", ack_total - ack0);
    else n_pass++;
    xfer(1'b0, 8'h20, 4'hF, 32'h0, 0, r);
    n_checks++;
    if (r !== d) $display("FAIL abort_committed got %h exp %h", r, d);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [7:0]  a;
    for (int i = 0; i < 8; i++) xfer(1'b1, 8'h30 + 8'(i), 4'hF, $urandom, 0, r);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 8'h80 + 8'($urandom_range(0, 127));
      else                           a = 8'h30 + 8'($urandom_range(0, 7));
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 0, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    test_abort_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
